input_port_fifo: RTL and testbench

INPUT_PORT_FIFO -- requirements
Module: input_port_fifo

---
 rtl/input_port_fifo_pkg.sv | 16 +
 rtl/input_port_fifo_if.sv | 30 +++
 rtl/input_port_fifo_fifo.sv | 54 +++++
 rtl/input_port_fifo.sv | 75 +++++++
 tb/tb_input_port_fifo.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/input_port_fifo_pkg.sv
// Shared processor package for the input port FIFO.
// Provides the default word width and depth, the pointer-width helper,
// and the default pointer width derived from it.
package input_port_fifo_pkg;

  localparam int unsigned LENGTH_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 4;

  // Pointer width for a power-of-two depth (depth >= 2).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/input_port_fifo_if.sv
// Handshake bundle between the external producer / processor and the
// input port FIFO.
//   master : producer/processor side - drives ExtData, ExtValid, RdReq, ClrErr
//   slave  : FIFO side               - drives ExtReady, RdData, DataAvail, Underflow
interface input_port_fifo_if
  import input_port_fifo_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF
);

  logic [LENGTH-1:0] ExtData;
  logic              ExtValid;
  logic              ExtReady;
  logic              RdReq;
  logic [LENGTH-1:0] RdData;
  logic              DataAvail;
  logic              Underflow;
  logic              ClrErr;

  modport master (
    output ExtData, ExtValid, RdReq, ClrErr,
    input  ExtReady, RdData, DataAvail, Underflow
  );

  modport slave (
    input  ExtData, ExtValid, RdReq, ClrErr,
    output ExtReady, RdData, DataAvail, Underflow
  );

endinterface

// File: rtl/input_port_fifo_fifo.sv
// input_fifo: storage array, head/tail pointers and occupancy count.
// Ports:
//   clk, nReset : clock, asynchronous active-low reset
//   push        : write wr_data at the tail this edge (caller guarantees not full)
//   pop         : advance the head this edge (caller guarantees not empty)
//   wr_data     : word to store
//   head_data   : word currently at the head
//   count       : number of stored words, 0..DEPTH
// Storage is not reset; only the pointers and count are.
module input_fifo
  import input_port_fifo_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned PW    = ptr_width(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              push,
  input  logic              pop,
  input  logic [LENGTH-1:0] wr_data,
  output logic [LENGTH-1:0] head_data,
  output logic [CW-1:0]     count
);

  logic [LENGTH-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/input_port_fifo.sv
// input_port_fifo: buffers words from an external producer for the processor's
// input instruction.
// Ports:
//   clk    : clock, rising edge
//   nReset : asynchronous active-low reset
//   bus    : input_port_fifo_if.slave
//            ExtData/ExtValid/ExtReady - producer handshake (push when both high)
//            RdReq/RdData              - processor read, RdData valid 1 cycle later
//            DataAvail                 - FIFO not empty
//            Underflow/ClrErr          - sticky empty-read flag and its clear
module input_port_fifo
  import input_port_fifo_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned CW    = ptr_width(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               nReset,
  input_port_fifo_if.slave   bus
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]     count;
  logic [LENGTH-1:0] head_data;
  logic              empty;
  logic              push;
  logic              pop;
  logic              underflow_ev;

  assign empty        = (count == '0);
  assign push         = bus.ExtValid && bus.ExtReady;
  // A read on an empty FIFO is never bypassed from a concurrent push.
  assign pop          = bus.RdReq && !empty;
  assign underflow_ev = bus.RdReq && empty;

  input_fifo #(
    .LENGTH (LENGTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nReset    (nReset),
    .push      (push),
    .pop       (pop),
    .wr_data   (bus.ExtData),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.ExtReady  = (count < DEPTH_C);
  assign bus.DataAvail = !empty;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bus.RdData <= '0;
    end else if (pop) begin
      bus.RdData <= head_data;
    end else if (underflow_ev) begin
      bus.RdData <= '0;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bus.Underflow <= 1'b0;
    end else if (underflow_ev) begin
      bus.Underflow <= 1'b1;
    end else if (bus.ClrErr) begin
      bus.Underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_port_fifo.sv
// Self-checking bench for input_port_fifo: table of directed vectors plus
// hand-written sequences for wrap-around and asynchronous reset.
module tb_input_port_fifo;

  logic clk;
  logic nReset;

  input_port_fifo_if #(.LENGTH(16)) bus ();

  input_port_fifo #(.LENGTH(16), .DEPTH(4)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        rd;
    logic        clr;
    logic [15:0] exp_rd;
    logic [2:0]  exp_cnt;
    logic        exp_ready;
    logic        exp_avail;
    logic        exp_uf;
  } vec_t;

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] rd, input logic [2:0] cnt,
                           input logic rdy, input logic av, input logic uf);
    check({tag, " RdData"},    32'(bus.RdData),         32'(rd));
    check({tag, " count"},     32'(dut.u_fifo.count),   32'(cnt));
    check({tag, " ExtReady"},  32'(bus.ExtReady),       32'(rdy));
    check({tag, " DataAvail"}, 32'(bus.DataAvail),      32'(av));
    check({tag, " Underflow"}, 32'(bus.Underflow),      32'(uf));
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic c);
    bus.ExtValid = v;
    bus.ExtData  = d;
    bus.RdReq    = r;
    bus.ClrErr   = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [$];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic r, input logic c,
                              input logic [15:0] er, input logic [2:0] ec,
                              input logic ery, input logic ea, input logic eu);
    vec_t x;
    x.valid = v; x.data = d; x.rd = r; x.clr = c;
    x.exp_rd = er; x.exp_cnt = ec; x.exp_ready = ery; x.exp_avail = ea; x.exp_uf = eu;
    return x;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    nReset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Outputs after each edge:        v  data      rd clr  RdData    cnt rdy av uf
    // basic flow
    vt.push_back(mk(1, 16'h1234, 0, 0, 16'h0000, 1, 1, 1, 0));
    vt.push_back(mk(1, 16'hABCD, 0, 0, 16'h0000, 2, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h1234, 1, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'hABCD, 0, 1, 0, 0));
    // fill (RdData holds ABCD while only pushing)
    vt.push_back(mk(1, 16'h1111, 0, 0, 16'hABCD, 1, 1, 1, 0));
    vt.push_back(mk(1, 16'h2222, 0, 0, 16'hABCD, 2, 1, 1, 0));
    vt.push_back(mk(1, 16'h3333, 0, 0, 16'hABCD, 3, 1, 1, 0));
    vt.push_back(mk(1, 16'h4444, 0, 0, 16'hABCD, 4, 0, 1, 0));
    vt.push_back(mk(1, 16'hDEAD, 0, 0, 16'hABCD, 4, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h1111, 3, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h2222, 2, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h3333, 1, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h4444, 0, 1, 0, 0));
    // underflow, sticky, clear
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 16'h0000, 0, 1, 0, 0));
    // simultaneous push/pop at count 2
    vt.push_back(mk(1, 16'h5555, 0, 0, 16'h0000, 1, 1, 1, 0));
    vt.push_back(mk(1, 16'h6666, 0, 0, 16'h0000, 2, 1, 1, 0));
    vt.push_back(mk(1, 16'h7777, 1, 0, 16'h5555, 2, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h6666, 1, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'h7777, 0, 1, 0, 0));
    // simultaneous at count 0: underflow, word stored
    vt.push_back(mk(1, 16'h8888, 1, 0, 16'h0000, 1, 1, 1, 1));
    // clear with a valid pop
    vt.push_back(mk(0, 16'h0000, 1, 1, 16'h8888, 0, 1, 0, 0));
    // clear and new underflow together: set wins
    vt.push_back(mk(0, 16'h0000, 1, 1, 16'h0000, 0, 1, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 16'h0000, 0, 1, 0, 0));
    // full: push+pop offered, only the pop happens
    vt.push_back(mk(1, 16'hA001, 0, 0, 16'h0000, 1, 1, 1, 0));
    vt.push_back(mk(1, 16'hA002, 0, 0, 16'h0000, 2, 1, 1, 0));
    vt.push_back(mk(1, 16'hA003, 0, 0, 16'h0000, 3, 1, 1, 0));
    vt.push_back(mk(1, 16'hA004, 0, 0, 16'h0000, 4, 0, 1, 0));
    vt.push_back(mk(1, 16'hB000, 1, 0, 16'hA001, 3, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'hA002, 2, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'hA003, 1, 1, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 16'hA004, 0, 1, 0, 0));

    #12;
    check_all("reset", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    nReset = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].valid, vt[i].data, vt[i].rd, vt[i].clr);
      tick();
      check_all($sformatf("vec%0d", i), vt[i].exp_rd, vt[i].exp_cnt,
                vt[i].exp_ready, vt[i].exp_avail, vt[i].exp_uf);
    end

    // wrap-around: 10 push/pop pairs
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      tick();
      check($sformatf("wrap%0d push count", i), 32'(dut.u_fifo.count), 32'd1);
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      tick();
      check($sformatf("wrap%0d RdData", i), 32'(bus.RdData), 32'(i));
      check($sformatf("wrap%0d pop count", i), 32'(dut.u_fifo.count), 32'd0);
    end

    // mid-operation reset with count 3 and RdData non-zero
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check_all("pre-reset", 16'hC000, 3'd3, 1'b1, 1'b1, 1'b0);
    #2;
    nReset = 1'b0;
    #1;
    check_all("async reset", 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    nReset = 1'b1;
    drive(1'b1, 16'hE001, 1'b0, 1'b0);
    tick();
    check("first push after reset count", 32'(dut.u_fifo.count), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check_all("post-reset pop", 16'hE001, 3'd0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
